// File: rtl/div_unit.sv
// Iterative restoring divider: one quotient bit per cycle, short paths for divide-by-zero
// and signed overflow. Define DIV_SIGNED_EN to add the is_signed port and signed support.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] dvs_r;
  logic [5:0]  cnt_r;
  logic        neg_q_r;
  logic        neg_r_r;

  logic        op_signed_s;
  logic        zero_s;
  logic        ovf_s;
  logic        dvd_neg_s;
  logic        dvs_neg_s;
  logic [31:0] dvd_mag_s;
  logic [31:0] dvs_mag_s;
  logic [32:0] shift_s;
  logic [32:0] diff_s;
  logic [31:0] rem_step_s;
  logic [31:0] quo_step_s;

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    cond_neg = neg ? (~v + 32'd1) : v;
  endfunction

`ifdef DIV_SIGNED_EN
  assign op_signed_s = is_signed;
  assign ovf_s       = is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
`else
  assign op_signed_s = 1'b0;
  assign ovf_s       = 1'b0;
`endif

  assign zero_s    = (divisor == 32'h0000_0000);
  assign dvd_neg_s = op_signed_s & dividend[31];
  assign dvs_neg_s = op_signed_s & divisor[31];
  assign dvd_mag_s = cond_neg(dividend, dvd_neg_s);
  assign dvs_mag_s = cond_neg(divisor, dvs_neg_s);

  // One restoring step: shift {rem,quo} left and trial-subtract the divisor magnitude.
  always_comb begin
    shift_s    = {rem_r, quo_r[31]};
    diff_s     = shift_s - {1'b0, dvs_r};
    rem_step_s = shift_s[31:0];
    quo_step_s = {quo_r[30:0], 1'b0};
    if (diff_s[32] == 1'b0) begin
      rem_step_s = diff_s[31:0];
      quo_step_s = {quo_r[30:0], 1'b1};
    end else begin
      rem_step_s = shift_s[31:0];
      quo_step_s = {quo_r[30:0], 1'b0};
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (zero_s || ovf_s) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == 6'd31) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and result registers; results load on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_r       <= 32'h0000_0000;
      quo_r       <= 32'h0000_0000;
      dvs_r       <= 32'h0000_0000;
      cnt_r       <= 6'd0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      quotient    <= 32'h0000_0000;
      remainder   <= 32'h0000_0000;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      busy <= (state_s != IDLE);
      done <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            rem_r   <= 32'h0000_0000;
            quo_r   <= dvd_mag_s;
            dvs_r   <= dvs_mag_s;
            cnt_r   <= 6'd0;
            neg_q_r <= dvd_neg_s ^ dvs_neg_s;
            neg_r_r <= dvd_neg_s;
            if (zero_s) begin
              quotient    <= 32'hFFFF_FFFF;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else if (ovf_s) begin
              quotient    <= 32'h8000_0000;
              remainder   <= 32'h0000_0000;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          rem_r <= rem_step_s;
          quo_r <= quo_step_s;
          cnt_r <= cnt_r + 6'd1;
          if (cnt_r == 6'd31) begin
            quotient    <= cond_neg(quo_step_s, neg_q_r);
            remainder   <= cond_neg(rem_step_s, neg_r_r);
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          cnt_r <= 6'd0;
        end
        default: begin
          cnt_r <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit; signed vectors are applied only when
// DIV_SIGNED_EN is defined.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;
`ifdef DIV_SIGNED_EN
  logic        is_signed;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
`ifdef DIV_SIGNED_EN
    .is_signed  (is_signed),
`endif
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_signed(input bit sgn);
`ifdef DIV_SIGNED_EN
    is_signed = sgn;
`else
    if (sgn) $display("signed vector skipped in unsigned build");
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " quotient"}, quotient, 32'h0);
    chk({tag, " remainder"}, remainder, 32'h0);
    chk({tag, " busy"}, {31'h0, busy}, 32'h0);
    chk({tag, " done"}, {31'h0, done}, 32'h0);
    chk({tag, " dz"}, {31'h0, div_by_zero}, 32'h0);
  endtask

  // Issue one op, wait (bounded) for done, check latency/results and the following cycle.
  task automatic do_op(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                       input bit sgn, input logic [31:0] eq, input logic [31:0] er,
                       input logic edz, input int elat);
    int lat;
    dividend = dvd;
    divisor  = dvs;
    set_signed(sgn);
    start    = 1'b1;
    tick;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat      = 1;
    while (done !== 1'b1 && lat < 100) begin
      tick;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " dz"}, {31'h0, div_by_zero}, {31'h0, edz});
    chk({tag, " busy@done"}, {31'h0, busy}, 32'h1);
    tick;
    chk({tag, " done pulse"}, {31'h0, done}, 32'h0);
    chk({tag, " busy after"}, {31'h0, busy}, 32'h0);
    tick;
    tick;
    chk({tag, " hold q"}, quotient, eq);
    chk({tag, " hold r"}, remainder, er);
  endtask

  initial begin
    int ndone;
    int d1;
    int d2;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = 32'h0;
    divisor  = 32'h0;
    set_signed(1'b0);
    tick;
    tick;
    chk_zero("reset");
    reset = 1'b0;
    tick;

    do_op("u100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33);
    do_op("div0", 32'h1234, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1);
    do_op("uFFFF/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 33);
    do_op("u5/9", 32'd5, 32'd9, 1'b0, 32'h0, 32'd5, 1'b0, 33);
    do_op("u8000/FFFF", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000, 1'b0, 33);
    do_op("uFFFF/FFFF", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'h0, 1'b0, 33);
`ifdef DIV_SIGNED_EN
    do_op("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    do_op("s7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
    do_op("s-7/-2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF, 1'b0, 33);
    do_op("sovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 1'b0, 1);
    do_op("sdiv0", 32'hFFFF_FFFB, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1);
    set_signed(1'b0);
`endif

    // Extra start pulses while busy are ignored.
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    tick;
    ndone = 0;
    d1    = 0;
    for (int c = 1; c <= 45; c++) begin
      if (done === 1'b1) begin
        ndone++;
        d1 = c;
        chk("ignore q", quotient, 32'd14);
      end
      start    = (c == 5 || c == 20);
      dividend = 32'd1000;
      divisor  = 32'd3;
      tick;
    end
    start = 1'b0;
    chk("ignore ndone", 32'(ndone), 32'd1);
    chk("ignore cycle", 32'(d1), 32'd33);
    tick;

    // Start held high: second op accepted on the first IDLE cycle.
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    tick;
    ndone = 0;
    d1    = 0;
    d2    = 0;
    for (int c = 1; c <= 70; c++) begin
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) d1 = c;
        else            d2 = c;
      end
      tick;
    end
    chk("held ndone", 32'(ndone), 32'd2);
    chk("held first", 32'(d1), 32'd33);
    chk("held second", 32'(d2), 32'd67);
    start = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk_zero("held reset");

    // Reset mid-operation discards it without a done pulse.
    dividend = 32'hFFFF_FFFF;
    divisor  = 32'd3;
    start    = 1'b1;
    tick;
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 10; c++) begin
      if (done === 1'b1) ndone++;
      if (c == 10) reset = 1'b1;
      tick;
    end
    reset = 1'b0;
    chk("midreset done", 32'(ndone), 32'd0);
    chk_zero("midreset");
    tick;
    do_op("u9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 33);

    // Reset wins over a simultaneous start.
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    reset    = 1'b1;
    tick;
    start = 1'b0;
    reset = 1'b0;
    chk("rst+start busy", {31'h0, busy}, 32'h0);
    tick;
    chk("rst+start busy2", {31'h0, busy}, 32'h0);
    chk("rst+start done", {31'h0, done}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider for the tinyRISC execute stage, built on repeated subtract-and-restore rather than the ripple add path. It accepts one operation per start pulse and iterates one quotient bit per cycle. Results are returned with a single-cycle done pulse and held until the next operation. Divide-by-zero and signed overflow are handled on short paths with fixed results.

## Interface
Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a divide; sampled only in IDLE.
- dividend  input  32  numerator; captured on accepted start.
- divisor  input  32  denominator; captured on accepted start.
- is_signed  input  1  two's-complement operation; present only with DIV_SIGNED_EN.
- quotient  output  32  registered quotient.
- remainder  output  32  registered remainder.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when quotient/remainder become valid.
- div_by_zero  output  1  registered flag; valid with done, held with results.

## Operation
- States: IDLE, RUN, DONE.
- IDLE + start=1: capture operands.
  - If divisor==0: go to DONE.
  - Signed and dividend==0x80000000 and divisor==0xFFFFFFFF: go to DONE.
  - Otherwise: go to RUN and clear the 6-bit iteration counter.
- RUN, per cycle: shift {rem,quo} left by 1, trial-subtract the divisor magnitude from rem.
  - Non-negative result: keep it and set the quotient LSB to 1.
  - Negative result: restore rem and set the quotient LSB to 0.
- RUN: after iteration 32 (counter==31), go to DONE.
- DONE: load quotient, remainder and div_by_zero, pulse done, then go to IDLE.
- Arithmetic: 33-bit trial subtract; unsigned magnitudes throughout.
- Signed mode:
  - Divide |dividend| by |divisor|.
  - Negate the quotient if the operand signs differ.
  - The remainder takes the sign of the dividend.
- Divide by zero: quotient=0xFFFFFFFF, remainder=dividend, div_by_zero=1.
- Signed overflow (0x80000000 / -1): quotient=0x80000000, remainder=0, div_by_zero=0.
- start in RUN or DONE is ignored; there is no queuing.
- Outputs hold their last values in IDLE until the next DONE.

## Timing
- Reset values: state=IDLE, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0.
- Normal latency: start sampled at edge N; RUN during cycles N+1..N+32; done=1 in cycle N+33; busy low and next start accepted at N+34.
- Short path (divide by zero or overflow): done=1 in cycle N+1; next start accepted at N+2.
- Throughput: one normal op per 34 cycles; back-to-back start held high is accepted on the first IDLE cycle.
- Operand inputs may change freely after the accepting edge.
- Reset asserted in any state: next cycle is IDLE with all outputs at reset values. An in-flight operation is discarded, with no done pulse.
- Reset and start in the same cycle: reset wins and start is dropped.

## Configuration
- DIV_SIGNED_EN defined:
  - The is_signed port exists.
  - The sign-fixup and signed-overflow short path are built.
- DIV_SIGNED_EN undefined:
  - No is_signed port; all operations are unsigned.
  - 0x80000000 / 0xFFFFFFFF runs the normal path: quotient=0, remainder=0x80000000, done at N+33.
  - Divide-by-zero behaviour is unchanged.

## Test plan
- Unsigned 100 / 7, start at cycle 0 -> done at cycle 33, quotient=14, remainder=2, div_by_zero=0, busy low at 34.
- Divide by zero: 0x1234 / 0 -> done at cycle 1, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
- Signed (DIV_SIGNED_EN): -7 / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). 0x80000000 / 0xFFFFFFFF -> done at cycle 1, quotient=0x80000000, remainder=0.
- start pulsed at cycles 5 and 20 during an op started at 0 -> only one done, at 33, with the first op's result. start held high from 0 -> second done at 67.
- Reset asserted at cycle 10 of 0xFFFFFFFF / 3 -> no done pulse, all outputs 0 at cycle 11. A new 9 / 3 started at 12 -> done at 45, quotient=3, remainder=0.
- Unsigned 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0. 5 / 9 -> quotient=0, remainder=5.
